// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared mode encoding for the LED pattern bank
package led_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_OFF   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_ON    = 2'd1;
    localparam logic [MODE_W-1:0] MODE_BLINK = 2'd2;
    localparam logic [MODE_W-1:0] MODE_PWM   = 2'd3;

endpackage

// File: rtl/led_channel.sv
// rtl/led_channel.sv - one LED channel: mode/period regs, tick counter, lit decode
// LED_PWM_EN adds the duty register and PWM decode; otherwise mode 11 acts as ON.
module led_channel
    import led_pkg::*;
#(
    parameter int                PER_W      = 16,
    parameter logic [MODE_W-1:0] RST_MODE   = MODE_OFF,
    parameter int                RST_PERIOD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              wr_en,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic [PER_W-1:0]  cfg_period,
    input  logic [PER_W-1:0]  cfg_duty,
    output logic              lit
);

    logic [MODE_W-1:0] mode;
    logic [PER_W-1:0]  period;
    logic [PER_W-1:0]  cnt;
    logic [PER_W-1:0]  p_eff;
    logic [PER_W-1:0]  cnt_last;
    logic              counting;
    logic              pwm_lit;

    always_comb begin
        p_eff    = (period == '0) ? PER_W'(1) : period;
        cnt_last = p_eff - PER_W'(1);
        counting = (mode == MODE_BLINK);
`ifdef LED_PWM_EN
        counting = counting || (mode == MODE_PWM);
`endif
    end

    // A write wins over a coincident tick, so the counter restarts cleanly at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= RST_MODE;
            period <= PER_W'(RST_PERIOD);
            cnt    <= '0;
        end else if (wr_en) begin
            mode   <= cfg_mode;
            period <= cfg_period;
            cnt    <= '0;
        end else if (!counting) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= (cnt >= cnt_last) ? '0 : cnt + PER_W'(1);
        end
    end

`ifdef LED_PWM_EN
    logic [PER_W-1:0] duty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty <= '0;
        end else if (wr_en) begin
            duty <= cfg_duty;
        end
    end

    assign pwm_lit = (cnt < duty);
`else
    logic unused_duty;
    assign unused_duty = ^cfg_duty;
    assign pwm_lit     = 1'b1;
`endif

    always_comb begin
        lit = 1'b0;
        case (mode)
            MODE_OFF:   lit = 1'b0;
            MODE_ON:    lit = 1'b1;
            MODE_BLINK: lit = (cnt < (p_eff >> 1));
            default:    lit = pwm_lit;
        endcase
    end

endmodule

// File: rtl/led_pattern_bank.sv
// rtl/led_pattern_bank.sv - N_CH LED pattern generator with valid/ready config port
// Optional PWM mode and duty registers are enabled by defining LED_PWM_EN.
module led_pattern_bank
    import led_pkg::*;
#(
    parameter  int N_CH       = 12,
    parameter  int PER_W      = 16,
    parameter  int PRESCALE   = 50000,
    parameter  int DEF_PERIOD = 500,
    parameter  int ACT_LOW    = 1,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic [PER_W-1:0]  cfg_period,
    input  logic [PER_W-1:0]  cfg_duty,
    output logic              cfg_err,
    output logic [N_CH-1:0]   led
);

    localparam int              PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [N_CH-1:0] UNLIT = (ACT_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

    logic [PS_W-1:0] presc;
    logic            tick;
    logic            accept;
    logic            ch_ok;
    logic [N_CH-1:0] wr_en;
    logic [N_CH-1:0] lit;

    assign tick   = (presc == PS_W'(PRESCALE - 1));
    assign accept = cfg_valid && cfg_ready;
    assign ch_ok  = (int'(cfg_ch) < N_CH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else begin
            presc <= tick ? '0 : presc + PS_W'(1);
        end
    end

    // Ready drops for the apply cycle following every accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
            led       <= UNLIT;
        end else begin
            cfg_ready <= !accept;
            cfg_err   <= accept && !ch_ok;
            led       <= lit ^ UNLIT;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : gen_ch
        assign wr_en[i] = accept && ch_ok && (int'(cfg_ch) == i);

        led_channel #(
            .PER_W      (PER_W),
            .RST_MODE   ((i == 0) ? MODE_BLINK : MODE_OFF),
            .RST_PERIOD ((i == 0) ? DEF_PERIOD : 0)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick       (tick),
            .wr_en      (wr_en[i]),
            .cfg_mode   (cfg_mode),
            .cfg_period (cfg_period),
            .cfg_duty   (cfg_duty),
            .lit        (lit[i])
        );
    end

endmodule

// File: tb/tb_led_pattern_bank.sv
// tb/tb_led_pattern_bank.sv - randomized self-checking bench for led_pattern_bank (4- and 6-channel builds)
module tb_led_pattern_bank;

    localparam int PS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid [2];
    logic [2:0] cfg_ch [2];
    logic [1:0] cfg_mode [2];
    logic [7:0] cfg_period [2];
    logic [7:0] cfg_duty [2];

    logic       rdy0, rdy1, err0, err1;
    logic [3:0] led4;
    logic [5:0] led6;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    led_pattern_bank #(.N_CH(4), .PER_W(8), .PRESCALE(PS), .DEF_PERIOD(4), .ACT_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid[0]), .cfg_ready(rdy0),
        .cfg_ch(cfg_ch[0][1:0]), .cfg_mode(cfg_mode[0]), .cfg_period(cfg_period[0]),
        .cfg_duty(cfg_duty[0]), .cfg_err(err0), .led(led4)
    );

    led_pattern_bank #(.N_CH(6), .PER_W(8), .PRESCALE(PS), .DEF_PERIOD(4), .ACT_LOW(1)) dut6 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid[1]), .cfg_ready(rdy1),
        .cfg_ch(cfg_ch[1]), .cfg_mode(cfg_mode[1]), .cfg_period(cfg_period[1]),
        .cfg_duty(cfg_duty[1]), .cfg_err(err1), .led(led6)
    );

    // Reference model: each channel remembers the edge of its last write; its counter
    // value is the number of ticks since that edge, modulo the effective period.
    int         e;
    int         m_mode [2][8];
    int         m_per [2][8];
    int         m_duty [2][8];
    int         m_w [2][8];
    logic       m_ready [2];
    logic       m_err [2];
    logic [7:0] m_led [2];

    function automatic int nch(input int k);
        return (k == 0) ? 4 : 6;
    endfunction

    function automatic bit m_lit(input int k, input int c);
        int p, n;
        p = (m_per[k][c] == 0) ? 1 : m_per[k][c];
        n = (e / PS - m_w[k][c] / PS) % p;
        case (m_mode[k][c])
            0: return 1'b0;
            1: return 1'b1;
            2: return n < p / 2;
            default: begin
`ifdef LED_PWM_EN
                return n < m_duty[k][c];
`else
                return 1'b1;
`endif
            end
        endcase
    endfunction

    function automatic logic [7:0] m_leds(input int k);
        logic [7:0] v;
        v = 8'h00;
        for (int c = 0; c < nch(k); c++) v[c] = !m_lit(k, c);
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e <= 0;
            for (int k = 0; k < 2; k++) begin
                m_ready[k] <= 1'b0;
                m_err[k]   <= 1'b0;
                m_led[k]   <= (k == 0) ? 8'h0F : 8'h3F;
                for (int c = 0; c < 8; c++) begin
                    m_mode[k][c] <= (c == 0) ? 2 : 0;
                    m_per[k][c]  <= (c == 0) ? 4 : 0;
                    m_duty[k][c] <= 0;
                    m_w[k][c]    <= 0;
                end
            end
        end else begin
            e <= e + 1;
            for (int k = 0; k < 2; k++) begin
                m_led[k]   <= m_leds(k);
                m_ready[k] <= !(cfg_valid[k] && m_ready[k]);
                m_err[k]   <= cfg_valid[k] && m_ready[k] && (int'(cfg_ch[k]) >= nch(k));
                if (cfg_valid[k] && m_ready[k] && (int'(cfg_ch[k]) < nch(k))) begin
                    m_mode[k][cfg_ch[k]] <= int'(cfg_mode[k]);
                    m_per[k][cfg_ch[k]]  <= int'(cfg_period[k]);
                    m_duty[k][cfg_ch[k]] <= int'(cfg_duty[k]);
                    m_w[k][cfg_ch[k]]    <= e + 1;
                end
            end
        end
    end

    logic [5:0] act0, exp0;
    logic [7:0] act1, exp1;
    assign act0 = {led4, rdy0, err0};
    assign exp0 = {m_led[0][3:0], m_ready[0], m_err[0]};
    assign act1 = {led6, rdy1, err1};
    assign exp1 = {m_led[1][5:0], m_ready[1], m_err[1]};

    task automatic write_cfg(input int k, input int ch, input int mode, input int per, input int duty);
        cfg_valid[k]  = 1'b1;
        cfg_ch[k]     = 3'(ch);
        cfg_mode[k]   = 2'(mode);
        cfg_period[k] = 8'(per);
        cfg_duty[k]   = 8'(duty);
        @(negedge clk);
        cfg_valid[k] = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (led4 !== 4'hF) begin fails++; $display("FAIL reset_led4 got %h want f", led4); end
        tests++; if (led6 !== 6'h3F) begin fails++; $display("FAIL reset_led6 got %h want 3f", led6); end
        tests++; if (rdy0 !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", rdy0); end
        tests++; if (err0 !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err0); end
        #2 rst_n = 1'b1;
        @(negedge clk);
        tests++; if (rdy0 !== 1'b1) begin fails++; $display("FAIL ready_after_release got %b want 1", rdy0); end
        for (int i = 0; i < 40; i++) begin
            tests++;
            if (act0 !== exp0) begin fails++; $display("FAIL idle_blink cyc %0d got %h want %h", i, act0, exp0); end
            tests++;
            if (led4[3:1] !== 3'b111) begin fails++; $display("FAIL idle_off cyc %0d got %b want 111", i, led4[3:1]); end
            @(negedge clk);
        end
    endtask

    task automatic test_blink;
        write_cfg(0, 2, 2, 6, 0);
        tests++; if (rdy0 !== 1'b0) begin fails++; $display("FAIL blink_apply_ready got %b want 0", rdy0); end
        for (int i = 0; i < 40; i++) begin
            tests++;
            if (act0 !== exp0) begin fails++; $display("FAIL blink cyc %0d got %h want %h", i, act0, exp0); end
            @(negedge clk);
        end
    endtask

    task automatic test_pwm;
        int duties [3];
        duties = '{2, 0, 9};
        for (int d = 0; d < 3; d++) begin
            write_cfg(0, 1, 3, 5, duties[d]);
            for (int i = 0; i < 44; i++) begin
                tests++;
                if (act0 !== exp0) begin fails++; $display("FAIL pwm duty %0d cyc %0d got %h want %h", duties[d], i, act0, exp0); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_err;
        int chs [3];
        chs = '{5, 6, 7};
        for (int j = 0; j < 3; j++) begin
            write_cfg(1, chs[j], 2, 3, 1);
            tests++;
            if (err1 !== (chs[j] >= 6)) begin fails++; $display("FAIL err_pulse ch %0d got %b want %b", chs[j], err1, chs[j] >= 6); end
            for (int i = 0; i < 16; i++) begin
                tests++;
                if (act1 !== exp1) begin fails++; $display("FAIL err_pattern ch %0d cyc %0d got %h want %h", chs[j], i, act1, exp1); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_back_to_back;
        int acc;
        acc = 0;
        for (int i = 0; i < 8 && ((e + 1) % PS != 0); i++) @(negedge clk);
        cfg_valid[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cfg_ch[0]     = 3'($urandom_range(0, 3));
            cfg_mode[0]   = 2'($urandom_range(2, 3));
            cfg_period[0] = 8'($urandom_range(2, 8));
            cfg_duty[0]   = 8'($urandom_range(0, 8));
            if (rdy0) acc++;
            @(negedge clk);
            tests++;
            if (act0 !== exp0) begin fails++; $display("FAIL b2b cyc %0d got %h want %h", i, act0, exp0); end
        end
        cfg_valid[0] = 1'b0;
        tests++; if (acc !== 2) begin fails++; $display("FAIL b2b_accept_count got %0d want 2", acc); end
        for (int i = 0; i < 30; i++) begin
            tests++;
            if (act0 !== exp0) begin fails++; $display("FAIL b2b_after cyc %0d got %h want %h", i, act0, exp0); end
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 30; n++) begin
            int k;
            k = int'($urandom_range(0, 1));
            write_cfg(k, int'($urandom_range(0, (k == 0) ? 3 : 7)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 9)), int'($urandom_range(0, 11)));
            for (int i = 0; i < int'($urandom_range(1, 20)); i++) begin
                tests++;
                if (act0 !== exp0) begin fails++; $display("FAIL random4 it %0d got %h want %h", n, act0, exp0); end
                tests++;
                if (act1 !== exp1) begin fails++; $display("FAIL random6 it %0d got %h want %h", n, act1, exp1); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_async_reset;
        write_cfg(0, 3, 1, 1, 0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++; if (led4 !== 4'hF) begin fails++; $display("FAIL async_led4 got %h want f", led4); end
        tests++; if (led6 !== 6'h3F) begin fails++; $display("FAIL async_led6 got %h want 3f", led6); end
        tests++; if (rdy0 !== 1'b0) begin fails++; $display("FAIL async_ready got %b want 0", rdy0); end
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            tests++;
            if (act0 !== exp0) begin fails++; $display("FAIL post_reset4 cyc %0d got %h want %h", i, act0, exp0); end
            tests++;
            if (act1 !== exp1) begin fails++; $display("FAIL post_reset6 cyc %0d got %h want %h", i, act1, exp1); end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            cfg_valid[k]  = 1'b0;
            cfg_ch[k]     = 3'd0;
            cfg_mode[k]   = 2'd0;
            cfg_period[k] = 8'd0;
            cfg_duty[k]   = 8'd0;
        end
        test_reset;
        test_blink;
        test_pwm;
        test_err;
        test_back_to_back;
        test_random;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
